// File: rtl/avalon_aes_interface.sv
// Avalon-MM register file and control FSM in front of an AES decrypt core.
// Define AES_TIMEOUT_EN to abort a RUN that lasts 4095 cycles without AES_DONE.
module avalon_aes_interface (
    input  logic         CLK,
    input  logic         RESET_N,
    input  logic         AVL_CS,
    input  logic         AVL_READ,
    input  logic         AVL_WRITE,
    input  logic [3:0]   AVL_ADDR,
    input  logic [3:0]   AVL_BYTE_EN,
    input  logic [31:0]  AVL_WRITEDATA,
    output logic [31:0]  AVL_READDATA,
    output logic [31:0]  EXPORT_DATA,
    output logic         AES_START,
    input  logic         AES_DONE,
    output logic [127:0] AES_KEY,
    output logic [127:0] AES_MSG_ENC,
    input  logic [127:0] AES_MSG_DEC
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFin
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] regs_q [16];
    logic [31:0] regs_d [16];
    logic [31:0] readdata_q, readdata_d;
    logic        host_wr;
    logic        addr_writable;

    assign host_wr = AVL_CS & AVL_WRITE;
    // MSG_DEC (8-11) and DONE (15) are owned by the FSM.
    assign addr_writable = !((AVL_ADDR >= 4'd8 && AVL_ADDR <= 4'd11) || AVL_ADDR == 4'd15);

`ifdef AES_TIMEOUT_EN
    localparam logic [11:0] TmoLast = 12'd4094;

    logic [11:0] tmo_cnt_q, tmo_cnt_d;
    logic        tmo_hit;

    // Counter is held at zero outside RUN, so it starts clean on every entry.
    always_comb begin
        tmo_cnt_d = '0;
        if (state_q == StRun) begin
            tmo_cnt_d = tmo_cnt_q + 12'd1;
        end
    end

    assign tmo_hit = (tmo_cnt_q == TmoLast);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        readdata_d = readdata_q;
        for (int i = 0; i < 16; i++) begin
            regs_d[i] = regs_q[i];
        end

        // Read samples the current register value, so a same-cycle write is not visible.
        if (AVL_CS && AVL_READ) begin
            readdata_d = regs_q[AVL_ADDR];
        end

        if (host_wr && addr_writable) begin
            for (int b = 0; b < 4; b++) begin
                if (AVL_BYTE_EN[b]) begin
                    regs_d[AVL_ADDR][8*b +: 8] = AVL_WRITEDATA[8*b +: 8];
                end
            end
        end

        unique case (state_q)
            StIdle: begin
                if (regs_q[14][0]) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (AES_DONE) begin
                    state_d        = StFin;
                    regs_d[8]      = AES_MSG_DEC[127:96];
                    regs_d[9]      = AES_MSG_DEC[95:64];
                    regs_d[10]     = AES_MSG_DEC[63:32];
                    regs_d[11]     = AES_MSG_DEC[31:0];
                    regs_d[15][1:0] = 2'b01;
                end
`ifdef AES_TIMEOUT_EN
                else if (tmo_hit) begin
                    state_d         = StFin;
                    regs_d[15][1:0] = 2'b11;
                end
`endif
            end
            StFin: begin
                if (!regs_q[14][0]) begin
                    state_d         = StIdle;
                    regs_d[15][1:0] = 2'b00;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= StIdle;
            readdata_q <= '0;
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            readdata_q <= readdata_d;
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign AVL_READDATA = readdata_q;
    assign EXPORT_DATA  = {regs_q[0][31:16], regs_q[3][15:0]};
    assign AES_START    = (state_q == StRun);
    assign AES_KEY      = {regs_q[0], regs_q[1], regs_q[2], regs_q[3]};
    assign AES_MSG_ENC  = {regs_q[4], regs_q[5], regs_q[6], regs_q[7]};

endmodule

// File: doc/avalon_aes_interface.md
AVALON_AES_INTERFACE -- requirements
Module: avalon_aes_interface

Interface
REQ-001 SHALL have port CLK, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port RESET_N, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port AVL_CS, input, 1 bit: Avalon-MM chip select.
REQ-004 SHALL have port AVL_READ, input, 1 bit: read strobe, qualified by AVL_CS.
REQ-005 SHALL have port AVL_WRITE, input, 1 bit: write strobe, qualified by AVL_CS.
REQ-006 SHALL have port AVL_ADDR, input, 4 bits: 32-bit word address, registers 0-15.
REQ-007 SHALL have port AVL_BYTE_EN, input, 4 bits: write byte enables.
REQ-008 SHALL have port AVL_WRITEDATA, input, 32 bits: write data.
REQ-009 SHALL have port AVL_READDATA, output, 32 bits: read data.
REQ-010 SHALL have port EXPORT_DATA, output, 32 bits: {reg0[31:16], reg3[15:0]} for the hex display.
REQ-011 SHALL have port AES_START, output, 1 bit: request to the AES decrypt core.
REQ-012 SHALL have port AES_DONE, input, 1 bit: completion from the AES core.
REQ-013 SHALL have port AES_KEY, output, 128 bits: {reg0,reg1,reg2,reg3}.
REQ-014 SHALL have port AES_MSG_ENC, output, 128 bits: {reg4,reg5,reg6,reg7}.
REQ-015 SHALL have port AES_MSG_DEC, input, 128 bits: decrypted result, valid while AES_DONE=1.

Function
REQ-016 Register map SHALL be: 0-3 KEY (R/W), 4-7 MSG_ENC (R/W), 8-11 MSG_DEC (RO; reg8 = bits 127:96), 12-13 spare (R/W), 14 START (R/W, bit0), 15 DONE (RO: bit0 done, bit1 timeout).
REQ-017 A write with AVL_CS&AVL_WRITE SHALL update only the bytes whose AVL_BYTE_EN bit is set; writes to 8-11 and 15 SHALL be ignored.
REQ-018 Read latency SHALL be 1 cycle: AVL_READDATA registered on the edge that samples AVL_CS&AVL_READ; otherwise it holds its last value.
REQ-019 A same-cycle read and write to one address SHALL return the pre-write value.
REQ-020 The FSM SHALL have states IDLE, RUN, FIN.
REQ-021 IDLE->RUN when START bit0 is 1 on a clock edge; AES_START=1 only in RUN.
REQ-022 RUN->FIN on the first edge with AES_DONE=1; that edge SHALL capture AES_MSG_DEC into regs 8-11 and set DONE bit0.
REQ-023 FIN->IDLE when START bit0 is 0; the same edge SHALL clear DONE bits 0 and 1. Regs 8-11 SHALL hold their value.
REQ-024 KEY/MSG_ENC writes during RUN SHALL take effect immediately; the core is responsible for latching its inputs at start.
REQ-025 AES_DONE outside RUN SHALL be ignored.

Reset
REQ-026 RESET_N low SHALL immediately force regs 0-15 to 0, FSM to IDLE, AES_START=0, AVL_READDATA=0, and EXPORT_DATA=0.
REQ-027 Reset asserted during RUN SHALL abort without capturing MSG_DEC; AES_DONE arriving after release with START=0 SHALL be ignored.

Configuration
REQ-028 Macro AES_TIMEOUT_EN SHALL, when defined, add a 12-bit cycle counter that is cleared on entry to RUN and increments each RUN cycle.
REQ-029 With AES_TIMEOUT_EN, reaching 4095 cycles in RUN without AES_DONE SHALL move the FSM to FIN with DONE=0b11 and leave regs 8-11 unchanged.
REQ-030 With AES_TIMEOUT_EN, AES_DONE on the timeout cycle SHALL take priority and set DONE=0b01.
REQ-031 Without AES_TIMEOUT_EN, RUN SHALL wait indefinitely and DONE bit1 SHALL read 0.

Verification
REQ-032 Write reg0=0x01234567, reg3=0x89ABCDEF -> EXPORT_DATA=0x0123CDEF; read reg0 returns 0x01234567 one cycle after the strobe.
REQ-033 Write reg5=0xFFFFFFFF with BYTE_EN=0b0101 after reg5=0 -> reg5 reads 0x00FF00FF.
REQ-034 Write START=1, AES_DONE pulses after 10 cycles with MSG_DEC=0xDAEC3055DF058E1C39E814EA76F6747E -> reg8 reads 0xDAEC3055, reg15 reads 1; write START=0 -> reg15 reads 0 and FSM is IDLE.
REQ-035 Write 0x12345678 to reg9 and to reg15 -> both read back unchanged.
REQ-036 With START=1 in RUN, pull RESET_N low for 1 cycle mid-cycle -> AES_START=0 immediately and all registers read 0.
REQ-037 With AES_TIMEOUT_EN and AES_DONE held 0 -> after 4095 RUN cycles reg15 reads 0x3 and AES_START=0.
